adder_tree_acc: RTL
===================

Name: adder_tree_acc

Overview:
- Parametrised pipelined signed adder tree with multi-beat accumulation for the SE block fully-connected layers (FC1/FC2) and any later FC-style reduction.
- Each accepted beat carries NUM_INPUTS products. Beats are reduced by a balanced binary tree and accumulated over a per-group beat count. A per-group bias is added.
- One result per group is emitted, with optional saturation. Replaces fixed 32-input / hard-coded FC1-FC2 loop selection with a generic group length.

Parameters:
- DATA_W, 21, signed width of each input word and of bias.
- LOG2_IN, 5, tree depth; NUM_INPUTS = 2**LOG2_IN (legal 1..6).
- LOOP_W, 5, width of loop_len; max group length 2**LOOP_W-1 beats.
- OUT_W, 31, signed output width; default DATA_W+LOG2_IN+LOOP_W (never overflows).
- SAT_EN, 1, 1 = saturate to OUT_W range, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  beat present this cycle
- in_data  in  NUM_INPUTS*DATA_W  packed signed words, word i at [i*DATA_W +: DATA_W]
- loop_len  in  LOOP_W  beats in group; sampled on first beat of a group
- bias  in  DATA_W  signed bias; sampled on first beat of a group
- abort  in  1  synchronous flush of group and pipeline
- out_valid  out  1  one-cycle pulse, result valid
- out_sum  out  OUT_W  signed group sum
- out_sat  out  1  saturation/overflow occurred for this result (qualified by out_valid)
- busy  out  1  group open or pipeline non-empty

Behaviour:
- Reset: one clock; reset is synchronous and active-high. rst=1 at a clk edge clears out_valid, out_sum, out_sat, busy, the beat counter, the accumulator and all stage valids to 0. Mid-operation reset discards everything. The first beat after reset starts a new group.
- No backpressure. in_valid may be high every cycle or have arbitrary gaps. A stage registers data only when its valid-in is 1; the valid bits shift every cycle.
- Input side: beat_cnt counts accepted beats.
  - First beat: beat_cnt==0. Latch len = (loop_len==0 ? 1 : loop_len) and bias.
  - Last beat: beat_cnt==len-1. beat_cnt returns to 0, so the next beat starts a new group.
  - first/last tags travel down the pipeline with the data.
- Tree: level k (1..LOG2_IN) sums pairs, width DATA_W+k, sign-extended, one register per level.
  - The last level also performs accumulation: acc <= (first ? sext(bias) : acc) + pair_sum.
  - Accumulator width is DATA_W+LOG2_IN+LOOP_W+1 (internal, never wraps).
- Latency: out_valid rises exactly LOG2_IN cycles after the in_valid cycle of the group's last beat. This is 5 cycles at defaults. No internal idle cycles are needed between groups; back-to-back groups produce independent sums.
- Output: on a last-tagged final stage, out_valid=1 for one cycle.
  - SAT_EN=1: out_sum = acc clamped to [-2**(OUT_W-1), 2**(OUT_W-1)-1]; out_sat=1 if clamped.
  - SAT_EN=0: out_sum = acc[OUT_W-1:0]; out_sat=1 if the value did not fit.
  - out_sum and out_sat hold their value until the next result.
- abort=1: next edge clears stage valids, beat_cnt and the accumulator. in_valid in the abort cycle is ignored. No out_valid for partial groups, including results already in flight. out_sum is held.
- busy = (beat_cnt!=0) | any stage valid.
- Simultaneous rst and abort: rst wins; the effect is identical.

Test Plan:
- Defaults, loop_len=1, bias=0, all 32 words=1, one beat -> exactly 5 cycles later out_valid=1 for one cycle, out_sum=32, out_sat=0.
- loop_len=18 (FC1), bias=100, 18 consecutive beats of all words=-1 -> single out_valid pulse, out_sum=-476. No pulse on beats 1..17.
- Group A loop_len=5 (all words=2) immediately followed by group B loop_len=2 (all words=3, bias=-4) with random in_valid gaps in B -> out_sum 320 then 188, no cross-group bleed.
- OUT_W=24, SAT_EN=1, loop_len=31, all words=2**20-1 -> out_sum=8388607, out_sat=1. Same with all words=-2**20 -> out_sum=-8388608, out_sat=1. SAT_EN=0, loop_len=31 -> out_sum equals the low 24 bits, out_sat=1.
- loop_len=0 with one beat of all words=1 -> treated as 1, out_sum=32.
- Abort/reset mid-group: abort after beat 3 of a loop_len=5 group, then a fresh loop_len=2 group of words=1 -> only one out_valid, out_sum=64. Repeat with rst instead of abort -> out_valid, out_sum and busy all 0 after reset, then the same result of 64.

Source files
------------

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree with per-group accumulation, bias and output saturation.
// Latency: out_valid LOG2_IN cycles after the in_valid cycle of a group's last beat.
// Backpressure: none; a beat is accepted on every in_valid cycle, and abort flushes everything.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_data    one beat of NUM_INPUTS signed DATA_W words (word i at [i*DATA_W +: DATA_W])
//   loop_len, bias       group length (0 means 1) and signed bias, sampled on a group's first beat
//   abort                synchronous flush of the open group and everything in flight
//   out_valid            one-cycle pulse per completed group
//   out_sum, out_sat     group result and overflow flag, held until the next result
//   busy                 group open or any beat still inside the tree
module adder_tree_acc #(
    parameter int DATA_W  = 21,
    parameter int LOG2_IN = 5,
    parameter int LOOP_W  = 5,
    parameter int OUT_W   = DATA_W + LOG2_IN + LOOP_W,
    parameter int SAT_EN  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [(2**LOG2_IN)*DATA_W-1:0]    in_data,
    input  logic [LOOP_W-1:0]                 loop_len,
    input  logic signed [DATA_W-1:0]          bias,
    input  logic                              abort,
    output logic                              out_valid,
    output logic signed [OUT_W-1:0]           out_sum,
    output logic                              out_sat,
    output logic                              busy
);

    localparam int NUM_INPUTS = 2**LOG2_IN;
    // One spare bit above the worst-case group sum so the accumulator never wraps.
    localparam int ACC_W      = DATA_W + LOG2_IN + LOOP_W + 1;
    localparam int L          = LOG2_IN - 1;     // last registered tree level feeding the accumulator
    localparam int PW         = DATA_W + LOG2_IN; // width of the final pair sum

    // ------------------------------------------------------------------
    // Group framing on the input side
    // ------------------------------------------------------------------
    logic [LOOP_W-1:0] beat_cnt;
    logic [LOOP_W-1:0] len_q;
    logic [LOOP_W-1:0] eff_len;
    logic              first0;
    logic              last0;

    always_comb begin
        eff_len = (loop_len == '0) ? LOOP_W'(1) : loop_len;
        first0  = (beat_cnt == '0);
        // On the first beat len_q is stale, so the live (sampled) length decides.
        last0   = first0 ? (eff_len == LOOP_W'(1)) : (beat_cnt == len_q - LOOP_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            len_q    <= '0;
        end else if (abort) begin
            beat_cnt <= '0;
        end else if (in_valid) begin
            if (first0) begin
                len_q <= eff_len;
            end
            beat_cnt <= last0 ? '0 : beat_cnt + LOOP_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Reduction tree. Level 0 is the unregistered input; levels 1..L are
    // registered pair sums. Tags and the group's bias ride along with the
    // data so back-to-back groups never share state.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LOG2_IN; k++) begin : g_lvl
        localparam int W = DATA_W + k;
        localparam int N = NUM_INPUTS >> k;

        logic signed [W-1:0]      s [N];
        logic                     vld;
        logic                     fst;
        logic                     lst;
        logic signed [DATA_W-1:0] bias_p;
        logic                     busy_or;

        if (k == 0) begin : g_in
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    s[i] = in_data[i*DATA_W +: DATA_W];
                end
            end
            assign vld     = in_valid;
            assign fst     = first0;
            assign lst     = last0;
            assign bias_p  = bias;
            assign busy_or = 1'b0;
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld <= 1'b0;
                end else begin
                    vld <= g_lvl[k-1].vld & ~abort;
                    if (g_lvl[k-1].vld) begin
                        fst    <= g_lvl[k-1].fst;
                        lst    <= g_lvl[k-1].lst;
                        bias_p <= g_lvl[k-1].bias_p;
                        for (int i = 0; i < N; i++) begin
                            s[i] <= W'(g_lvl[k-1].s[2*i]) + W'(g_lvl[k-1].s[2*i+1]);
                        end
                    end
                end
            end
            assign busy_or = g_lvl[k-1].busy_or | vld;
        end
    end

    // ------------------------------------------------------------------
    // Final level: last pair sum folded straight into the accumulator
    // ------------------------------------------------------------------
    logic signed [PW-1:0]    pair_sum;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    logic [OUT_W-1:0]        res_sum;
    logic                    res_ovf;

    always_comb begin
        pair_sum = PW'(g_lvl[L].s[0]) + PW'(g_lvl[L].s[1]);
        acc_base = g_lvl[L].fst ? ACC_W'(g_lvl[L].bias_p) : acc;
        acc_next = acc_base + ACC_W'(pair_sum);
    end

    if (OUT_W >= ACC_W) begin : g_nosat
        always_comb begin
            res_sum = OUT_W'(acc_next);
            res_ovf = 1'b0;
        end
    end else begin : g_sat
        // The value fits iff every bit from the output sign bit upward agrees.
        logic [ACC_W-OUT_W:0] hi;
        always_comb begin
            hi      = acc_next[ACC_W-1:OUT_W-1];
            res_ovf = ~((&hi) | ~(|hi));
            if ((SAT_EN != 0) && res_ovf) begin
                res_sum = acc_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                res_sum = acc_next[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (abort) begin
                acc <= '0;
            end else if (g_lvl[L].vld) begin
                acc <= acc_next;
                if (g_lvl[L].lst) begin
                    out_valid <= 1'b1;
                    out_sum   <= res_sum;
                    out_sat   <= res_ovf;
                end
            end
        end
    end

    assign busy = (beat_cnt != '0) | g_lvl[L].busy_or;

endmodule
